// File: rtl/contador_bcd_display.sv
// Multi-digit BCD up/down counter with prescaled stepping and per-digit
// enables (optional leading-zero blanking) for a 7-segment converter stage.
module contador_bcd_display #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  blank_lz,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  carry,
    output logic                  tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic                carry_q, carry_d;
    logic                tick_q, tick_d;
    logic [4*DIGITS-1:0] stepped;
    logic [4*DIGITS-1:0] loaded;
    logic                wrap;
    logic                ripple;
    logic [3:0]          nib;
    logic                step;

    assign step = run && (presc_q == PTOP);

    // Ripple increment/decrement across digits; wrap is the carry/borrow out of the top digit
    always_comb begin
        stepped = digits_q;
        ripple  = 1'b1;
        nib     = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            nib = digits_q[4*i +: 4];
            if (ripple) begin
                if (up) begin
                    if (nib >= 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = nib + 4'd1;
                        ripple = 1'b0;
                    end
                end else begin
                    if (nib == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = nib - 4'd1;
                        ripple = 1'b0;
                    end
                end
            end
        end
        wrap = ripple;
    end

    // Saturate out-of-range load fields to 9 so stored digits stay valid BCD
    always_comb begin
        loaded = load_value;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (load_value[4*i +: 4] > 4'd9) begin
                loaded[4*i +: 4] = 4'd9;
            end
        end
    end

    // Next-state selection: clear > load > step > hold
    always_comb begin
        presc_d  = presc_q;
        digits_d = digits_q;
        carry_d  = 1'b0;
        tick_d   = 1'b0;
        if (clear) begin
            presc_d  = '0;
            digits_d = '0;
        end else if (load) begin
            presc_d  = '0;
            digits_d = loaded;
        end else if (run) begin
            if (step) begin
                presc_d  = '0;
                digits_d = stepped;
                tick_d   = 1'b1;
                carry_d  = wrap;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q  <= '0;
            digits_q <= '0;
            carry_q  <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            digits_q <= digits_d;
            carry_q  <= carry_d;
            tick_q   <= tick_d;
        end
    end

    // A digit is enabled if blanking is off, it is digit 0, or it or any higher digit is nonzero
    always_comb begin
        logic nz;
        nz       = 1'b0;
        digit_en = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            nz          = nz || (digits_q[4*i +: 4] != 4'd0);
            digit_en[i] = !blank_lz || nz || (i == 0);
        end
    end

    assign digits = digits_q;
    assign carry  = carry_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_contador_bcd_display.sv
// Self-checking bench for contador_bcd_display (DIGITS=4, PRESCALE=4).
// A decimal-integer reference model pushes expected outputs into a scoreboard
// queue before each clock edge; they are popped and compared after the edge.
module tb_contador_bcd_display;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned PRESCALE = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run, up, clear, load, blank_lz;
    logic [15:0] load_value;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic        carry, tick;

    typedef struct {
        logic [15:0] digits;
        logic        tick;
        logic        carry;
        logic [3:0]  en;
    } exp_t;

    exp_t sb[$];

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: count as a plain decimal integer
    int m_val   = 0;
    int m_presc = 0;

    contador_bcd_display #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .up         (up),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .blank_lz   (blank_lz),
        .digits     (digits),
        .digit_en   (digit_en),
        .carry      (carry),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int sat_value(input logic [15:0] lv);
        int v;
        int p;
        int n;
        v = 0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            n = int'(lv[4*i +: 4]);
            if (n > 9) n = 9;
            v = v + n * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_en(input int v, input logic blz);
        int n;
        if (!blz) return 4'hF;
        n = 1;
        if (v >= 10)   n = 2;
        if (v >= 100)  n = 3;
        if (v >= 1000) n = 4;
        return 4'((1 << n) - 1);
    endfunction

    // Advance model by one edge, push expectation, clock, pop and compare
    task automatic cycle();
        exp_t e;
        exp_t g;
        e.tick  = 1'b0;
        e.carry = 1'b0;
        if (clear) begin
            m_val   = 0;
            m_presc = 0;
        end else if (load) begin
            m_val   = sat_value(load_value);
            m_presc = 0;
        end else if (run) begin
            if (m_presc == PRESCALE - 1) begin
                m_presc = 0;
                e.tick  = 1'b1;
                if (up) begin
                    e.carry = (m_val == 9999);
                    m_val   = (m_val + 1) % 10000;
                end else begin
                    e.carry = (m_val == 0);
                    m_val   = (m_val == 0) ? 9999 : m_val - 1;
                end
            end else begin
                m_presc++;
            end
        end
        e.digits = to_bcd(m_val);
        e.en     = exp_en(m_val, blank_lz);
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("digits",   32'(digits),   32'(g.digits));
        check("tick",     32'(tick),     32'(g.tick));
        check("carry",    32'(carry),    32'(g.carry));
        check("digit_en", 32'(digit_en), 32'(g.en));
    endtask

    task automatic do_load(input logic [15:0] v);
        load       = 1'b1;
        load_value = v;
        cycle();
        load       = 1'b0;
    endtask

    initial begin : main
        int first;
        bit seen;

        reset_n    = 1'b0;
        run        = 1'b0;
        up         = 1'b1;
        clear      = 1'b0;
        load       = 1'b0;
        load_value = '0;
        blank_lz   = 1'b0;

        // Reset state
        #3;
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_tick",   32'(tick),   32'h0);
        check("rst_carry",  32'(carry),  32'h0);
        check("rst_en_off", 32'(digit_en), 32'hF);
        blank_lz = 1'b1;
        #1;
        check("rst_en_on",  32'(digit_en), 32'h1);
        blank_lz = 1'b0;
        #9;
        reset_n = 1'b1;

        // 1: free count up for 40 cycles
        run = 1'b1;
        up  = 1'b1;
        for (int i = 0; i < 40; i++) cycle();
        check("t1_digits", 32'(digits), 32'h0010);

        // 2: ripple 0999 -> 1000
        run = 1'b0;
        do_load(16'h0999);
        run      = 1'b1;
        blank_lz = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("t2_digits", 32'(digits), 32'h1000);
        check("t2_en",     32'(digit_en), 32'hF);

        // 3: wrap up and down
        run = 1'b0;
        do_load(16'h9999);
        run = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("t3_wrap_up", 32'(carry), 32'h1);
        cycle();
        run = 1'b0;
        do_load(16'h0000);
        run = 1'b1;
        up  = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("t3_dn_digits", 32'(digits), 32'h9999);
        check("t3_wrap_dn",   32'(carry),  32'h1);
        for (int i = 0; i < 6; i++) cycle();

        // 4: leading-zero blanking
        run = 1'b0;
        up  = 1'b1;
        do_load(16'h0000);
        do_load(16'h0305);
        check("t4_en_0305", 32'(digit_en), 32'h7);
        blank_lz = 1'b0;
        cycle();

        // 5: load saturation and clear-over-load priority
        do_load(16'hA0F3);
        check("t5_sat", 32'(digits), 32'h9093);
        clear = 1'b1;
        do_load(16'h1234);
        clear = 1'b0;
        run   = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // 6: async reset mid-count at prescaler=2
        run = 1'b0;
        do_load(16'h0042);
        run = 1'b1;
        cycle();
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_digits", 32'(digits), 32'h0);
        check("t6_tick",   32'(tick),   32'h0);
        check("t6_carry",  32'(carry),  32'h0);
        m_val   = 0;
        m_presc = 0;
        #1;
        reset_n = 1'b1;
        seen  = 1'b0;
        first = 0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            cycle();
            if (tick) begin
                seen  = 1'b1;
                first = k;
            end
        end
        check("t6_first_tick", 32'(first), 32'd4);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
